// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath widths, reset vector, base opcodes and the
// fetch-buffer entry type used between the fetch unit and the control unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b000_0011,
    OP_IMM    = 7'b001_0011,
    OP_AUIPC  = 7'b001_0111,
    OP_STORE  = 7'b010_0011,
    OP_REG    = 7'b011_0011,
    OP_LUI    = 7'b011_0111,
    OP_BRANCH = 7'b110_0011,
    OP_JALR   = 7'b110_0111,
    OP_JAL    = 7'b110_1111,
    OP_SYSTEM = 7'b111_0011
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode.
// Flush empties it in one cycle; the head is always visible on head_o.
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rptr_q;
  logic         wptr_q;
  logic [1:0]   count_q;
  logic         do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the two entries are reset so dec_instr/dec_pc read zero out of
      // reset; a deeper buffer would reset only its pointers and count.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request stream to imem, in-order response
// tracking, redirect with drop of stale responses, 2-entry decode buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      in_flight_q, in_flight_d;
  logic [1:0]      drop_q, drop_d;
  logic            started_q;

  logic [XLEN-1:0] pend_pc_q [2];
  logic            pend_wptr_q;
  logic            pend_rptr_q;

  logic            req_fire;
  logic            dec_fire;
  logic            rsp_drop;
  logic            buf_push;
  logic            buf_full;
  logic            buf_empty;
  logic [1:0]      buf_count;
  logic [2:0]      credit_used;
  fetch_entry_t    buf_head;
  fetch_entry_t    push_entry;

  assign dec_valid = !buf_empty;
  assign dec_instr = buf_head.instr;
  assign dec_pc    = buf_head.pc;
  assign dec_fire  = dec_valid && dec_ready;

  // A same-cycle pop frees its slot, which keeps a 1-cycle memory streaming.
  assign credit_used    = {1'b0, in_flight_q} + {1'b0, buf_count} - {2'b00, dec_fire};
  assign imem_req_valid = rst_n && started_q && !redirect_valid
                          && (credit_used < 3'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = redirect_valid || (drop_q != 2'd0);
  assign buf_push   = imem_rsp_valid && !rsp_drop;
  assign push_entry = '{pc: pend_pc_q[pend_rptr_q], instr: imem_rsp_data};

  // NOTE: combinational next-state uses blocking '=' with every target given
  // a default first, so no latch can be inferred; state updates use '<='.
  always_comb begin
    pc_d        = pc_q;
    in_flight_d = in_flight_q + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
    drop_d      = drop_q;
    if (redirect_valid) begin
      pc_d   = align_pc(redirect_pc);
      drop_d = in_flight_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= align_pc(RESET_PC);
      in_flight_q <= 2'd0;
      drop_q      <= 2'd0;
      started_q   <= 1'b0;
      pend_wptr_q <= 1'b0;
      pend_rptr_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      started_q   <= 1'b1;
      if (req_fire) begin
        pend_wptr_q <= ~pend_wptr_q;
      end
      if (imem_rsp_valid) begin
        pend_rptr_q <= ~pend_rptr_q;
      end
      assert (!(buf_push && buf_full));
    end
  end

  // Pending-PC entries are always written before being read; only pointers reset.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pend_pc_q[pend_wptr_q] <= pc_q;
    end
  end

  fetch_buffer u_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (buf_push),
    .push_data_i (push_entry),
    .pop_i       (dec_fire),
    .flush_i     (redirect_valid),
    .head_o      (buf_head),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

endmodule
